// File: rtl/seg7_pkg.sv
// Shared constants for the Basys3 seven-segment scanner: cathode decode table,
// all-off patterns and the scan state encoding.
package seg7_pkg;

  typedef enum logic {DRIVE, GUARD} state_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}; entry 15 is the MSB slice, codes 10-15 show a dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_bcd];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with an all-off guard gap between digits.
// Optional digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int GUARD_CYC   = 100,
  parameter int BLINK_HALF  = 50_000_000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [GW-1:0] GRD_LAST = GW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [RW-1:0] r_refCnt;
  logic [GW-1:0] r_grdCnt;
  logic [3:0]    w_bcd;
  logic [6:0]    w_seg;
  logic          w_blinkHide;

  assign w_bcd = digits[{r_idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (w_bcd),
    .o_seg (w_seg)
  );

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] r_blinkCnt;
  logic          r_blinkOn;

  // Free-running blink phase, deliberately not aligned to the scan frame.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_blinkCnt <= '0;
      r_blinkOn  <= 1'b1;
    end else if (r_blinkCnt == BLINK_LAST) begin
      r_blinkCnt <= '0;
      r_blinkOn  <= ~r_blinkOn;
    end else begin
      r_blinkCnt <= r_blinkCnt + BW'(1);
    end
  end

  assign w_blinkHide = ~r_blinkOn & blink_mask[r_idx];
`else
  logic w_unusedBlink;
  assign w_unusedBlink = ^{blink_mask, 1'(BLINK_HALF)};
  assign w_blinkHide   = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state  <= DRIVE;
      r_idx    <= 2'd0;
      r_refCnt <= '0;
      r_grdCnt <= '0;
      an       <= ANODE_OFF;
      seg      <= SEG_OFF;
      dp       <= 1'b1;
    end else begin
      case (r_state)
        DRIVE: begin
          an  <= (blank[r_idx] | w_blinkHide) ? ANODE_OFF : ~(4'b0001 << r_idx);
          seg <= w_seg;
          dp  <= w_blinkHide | ~dp_in[r_idx];
          if (r_refCnt == REF_LAST) begin
            r_refCnt <= '0;
            // With no guard interval the next digit follows immediately.
            if (GUARD_CYC == 0) r_idx   <= r_idx + 2'd1;
            else                r_state <= GUARD;
          end else begin
            r_refCnt <= r_refCnt + RW'(1);
          end
        end
        GUARD: begin
          an  <= ANODE_OFF;
          seg <= SEG_OFF;
          dp  <= 1'b1;
          if (r_grdCnt == GRD_LAST) begin
            r_grdCnt <= '0;
            r_idx    <= r_idx + 2'd1;
            r_state  <= DRIVE;
          end else begin
            r_grdCnt <= r_grdCnt + GW'(1);
          end
        end
        default: r_state <= DRIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a frame-arithmetic reference model predicts every
// output cycle, a separate monitor compares on the falling edge.
module tb_seg7_scan;

  localparam int R     = 4;
  localparam int G     = 2;
  localparam int BH    = 8;
  localparam int SLOT  = R + G;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } outRec_t;

  localparam outRec_t DARK = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};

  logic        clk_in = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  logic [6:0] segTab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  outRec_t expQ[$];
  int      k = 0;
  bit      running = 1'b0;
  int      checks = 0;
  int      failures = 0;

  seg7_scan #(
    .REFRESH_DIV (R),
    .GUARD_CYC   (G),
    .BLINK_HALF  (BH)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank      (blank),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk_in = ~clk_in;

  // Expected output after the k-th clock edge since reset release.
  function automatic outRec_t model(int kk, logic [15:0] d, logic [3:0] dpi,
                                    logic [3:0] bl, logic [3:0] bm);
    outRec_t r;
    int p, dig, w;
    bit blinkOff, hideBk;
    p   = kk % FRAME;
    dig = p / SLOT;
    w   = p % SLOT;
`ifdef SEG7_BLINK_EN
    blinkOff = ((kk / BH) % 2) == 1;
`else
    blinkOff = 1'b0;
`endif
    if (w >= R) begin
      r = DARK;
    end else begin
      hideBk = blinkOff & bm[dig];
      r.an   = (bl[dig] | hideBk) ? 4'b1111 : ~(4'b0001 << dig);
      r.seg  = segTab[d[dig*4 +: 4]];
      r.dp   = hideBk ? 1'b1 : ~dpi[dig];
    end
    return r;
  endfunction

  // Stimulus side of the scoreboard: predict the response of each edge.
  always @(posedge clk_in) begin
    if (running) begin
      expQ.push_back(model(k, digits, dp_in, blank, blink_mask));
      k = k + 1;
    end else begin
      k = 0;
    end
  end

  task automatic checkOutput(string name, outRec_t want);
    outRec_t got;
    got = '{an: an, seg: seg, dp: dp};
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("[TB] FAIL %s at %0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, $time, got.an, got.seg, got.dp, want.an, want.seg, want.dp);
    end
  endtask

  // Monitor: checks darkness right after reset rises, then one prediction per cycle.
  initial begin
    forever begin
      @(negedge clk_in or posedge rst);
      if (rst) begin
        #1;
        checkOutput("reset_dark", DARK);
        expQ.delete();
      end else if (expQ.size() > 0) begin
        checkOutput("scan", expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(logic [15:0] d, logic [3:0] dpi, logic [3:0] bl,
                               logic [3:0] bm, int n);
    digits     = d;
    dp_in      = dpi;
    blank      = bl;
    blink_mask = bm;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic randomBurst(int blocks);
    for (int i = 0; i < blocks; i++) begin
      applyStimulus(16'($urandom), 4'($urandom),
                    ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                    4'($urandom), $urandom_range(1, 12));
    end
  endtask

  initial begin
    rst        = 1'b0;
    digits     = 16'h0000;
    dp_in      = 4'b0000;
    blank      = 4'b0000;
    blink_mask = 4'b0000;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk_in);
    #1;
    rst     = 1'b0;
    running = 1'b1;

    applyStimulus(16'h1234, 4'b0000, 4'b0000, 4'b0000, 30);
    applyStimulus(16'h349C, 4'b0010, 4'b0100, 4'b0001, 50);
    applyStimulus(16'hFA09, 4'b1001, 4'b0000, 4'b0001, 30);
    randomBurst(25);

    // Asynchronous reset in the middle of the digit2 drive window.
    applyStimulus(16'h5678, 4'b0100, 4'b0000, 4'b0000, 1);
    for (int i = 0; i < 200 && (k % FRAME) != 14; i++) begin
      @(posedge clk_in);
      #1;
    end
    #1;
    rst     = 1'b1;
    running = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    rst     = 1'b0;
    running = 1'b1;

    applyStimulus(16'h2468, 4'b0001, 4'b0000, 4'b0000, 30);
    randomBurst(15);
    repeat (2) @(posedge clk_in);
    #6;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
